divisor: RTL and testbench
==========================

DIVISOR -- requirements
Module: divisor

Interface
REQ-001 The block SHALL expose parameter N, default 16, operand/result width in bits.
REQ-002 Clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of Clk.
REQ-004 St  input  1  start request; sampled on a rising Clk edge only while Busy=0.
REQ-005 Dividendo  input  N  unsigned dividend; captured on the edge that accepts St.
REQ-006 Divisor  input  N  unsigned divisor; captured on the edge that accepts St.
REQ-007 Quociente  output  N  registered unsigned quotient of the last completed operation.
REQ-008 Resto  output  N  registered unsigned remainder of the last completed operation.
REQ-009 Done  output  1  one-cycle completion pulse; Quociente/Resto/DivZero are valid while Done=1.
REQ-010 Busy  output  1  high while an operation is in progress; St is ignored while high.
REQ-011 DivZero  output  1  registered flag; 1 when the last completed operation had Divisor=0.

Function
REQ-012 The block SHALL implement a restoring shift-subtract divider, one quotient bit per cycle; it is the inverse companion of the shift-add multiplier.
REQ-013 The FSM SHALL have the states IDLE, RUN and FIM, with FIM lasting exactly one cycle.
REQ-014 IDLE, St=1, Divisor!=0: capture operands, clear the internal remainder register R (N+1 bits), load the internal quotient/shift register Q with Dividendo, set counter to N, and go to RUN.
REQ-015 IDLE, St=1, Divisor=0: go to FIM without iterating, using Quociente={N{1}}, Resto=Dividendo, DivZero=1.
REQ-016 Each RUN cycle SHALL left-shift {R,Q} by 1 and form T = R - D.
REQ-017 If T>=0, each RUN cycle SHALL set R=T and Q[0]=1.
REQ-018 If T<0, each RUN cycle SHALL keep R and set Q[0]=0.
REQ-019 Each RUN cycle SHALL decrement the counter.
REQ-020 The subtraction SHALL be performed at N+1 bits so that no carry is lost for dividends/divisors with MSB=1.
REQ-021 On the edge that performs the N-th iteration, the FSM SHALL go to FIM and load Quociente=Q and Resto=R[N-1:0] from that iteration's results, with DivZero=0.
REQ-022 Latency SHALL be N cycles from St acceptance to Done=1 for a nonzero divisor, and 1 cycle for Divisor=0.
REQ-023 Busy SHALL be 1 in RUN only.
REQ-024 Busy SHALL be 0 in IDLE and FIM.
REQ-025 Done SHALL be 1 in FIM only.
REQ-026 From FIM the FSM SHALL return to IDLE, unless St=1, in which case it accepts the new operation exactly as from IDLE (back-to-back operation, no dead cycle).
REQ-027 St=1 while Busy=1 SHALL be ignored, and captured operands SHALL NOT change.
REQ-028 Dividendo and Divisor changing during RUN SHALL NOT affect the result.
REQ-029 Quociente, Resto and DivZero SHALL hold their values from FIM until the next FIM.
REQ-030 Results SHALL satisfy Dividendo = Quociente*Divisor + Resto with Resto < Divisor, for all Divisor!=0.

Reset
REQ-031 While rst=0, the block SHALL set state=IDLE, counter=0, R=0, Q=0, Quociente=0, Resto=0, Done=0, Busy=0 and DivZero=0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no Done pulse.
REQ-033 After rst returns to 1, the first St SHALL start a fresh operation.

Verification
REQ-034 Dividendo=100, Divisor=7, St pulse -> Busy=1 for 15 cycles, then Done=1 on the 16th cycle with Quociente=14, Resto=2, DivZero=0.
REQ-035 Dividendo=0xFFFF, Divisor=0x0001 -> Quociente=0xFFFF, Resto=0; Dividendo=0xFFFF, Divisor=0x8000 -> Quociente=1, Resto=0x7FFF (checks the N+1-bit subtract).
REQ-036 Dividendo=5, Divisor=0 -> Done=1 on the next cycle with Quociente=0xFFFF, Resto=5, DivZero=1; then 3/10 -> Quociente=0, Resto=3, DivZero=0.
REQ-037 St=1 with 50/6, then St held high and operands changed to 9/2 during RUN -> first Done gives Quociente=8, Resto=2; St still high in FIM starts 9/2 -> next Done gives Quociente=4, Resto=1.
REQ-038 rst=0 asserted mid-RUN (asynchronous, between Clk edges) -> all outputs 0 immediately, no Done; after release, 20/4 -> Quociente=5, Resto=0.

Source files
------------

// File: rtl/divisor_if.sv
// rtl/divisor_if.sv - start/operand/result bundle for the restoring divider
interface divisor_if #(
    parameter int N = 16
);
    logic         St;
    logic [N-1:0] Dividendo;
    logic [N-1:0] Divisor;
    logic [N-1:0] Quociente;
    logic [N-1:0] Resto;
    logic         Done;
    logic         Busy;
    logic         DivZero;

    modport master (
        output St, Dividendo, Divisor,
        input  Quociente, Resto, Done, Busy, DivZero
    );

    modport slave (
        input  St, Dividendo, Divisor,
        output Quociente, Resto, Done, Busy, DivZero
    );
endinterface

// File: rtl/divisor.sv
// rtl/divisor.sv - unsigned restoring shift-subtract divider, one quotient bit per cycle
module divisor #(
    parameter int N = 16
) (
    input  logic     Clk,
    input  logic     rst,
    divisor_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIM} state_t;

    state_t          state_q, state_d;
    logic [N:0]      r_q, r_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    quo_q, quo_d;
    logic [N-1:0]    res_q, res_d;
    logic            dz_q, dz_d;

    logic [N:0]      src_r;
    logic [N-1:0]    src_q;
    logic [N-1:0]    src_d;
    logic [N+1:0]    shifted;
    logic [N+1:0]    diff;
    logic            neg;
    logic [N:0]      step_r;
    logic [N-1:0]    step_q;

    // The accepting edge already performs the first iteration from {0, Dividendo},
    // so RUN only needs N-1 more cycles and Done lands N cycles after acceptance.
    always_comb begin
        src_r   = (state_q == RUN) ? r_q : '0;
        src_q   = (state_q == RUN) ? q_q : bus.Dividendo;
        src_d   = (state_q == RUN) ? d_q : bus.Divisor;
        shifted = {src_r, src_q[N-1]};
        diff    = shifted - {2'b00, src_d};
        neg     = diff[N+1];
        step_r  = neg ? shifted[N:0] : diff[N:0];
        step_q  = {src_q[N-2:0], ~neg};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE, FIM: begin
                state_d = IDLE;
                if (bus.St) begin
                    d_d = bus.Divisor;
                    if (bus.Divisor == '0) begin
                        state_d = FIM;
                        r_d     = '0;
                        q_d     = bus.Dividendo;
                        cnt_d   = '0;
                        quo_d   = '1;
                        res_d   = bus.Dividendo;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_d     = step_r;
                        q_d     = step_q;
                        cnt_d   = CW'(N - 1);
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIM;
                    quo_d   = step_q;
                    res_d   = step_r[N-1:0];
                    dz_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.Quociente = quo_q;
    assign bus.Resto     = res_q;
    assign bus.DivZero   = dz_q;
    assign bus.Done      = (state_q == FIM);
    assign bus.Busy      = (state_q == RUN);
endmodule

// File: tb/tb_divisor.sv
// tb/tb_divisor.sv - scoreboard bench for the divisor block
module tb_divisor;
    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] quo;
        logic [N-1:0] res;
        logic         dz;
    } exp_t;

    logic Clk = 1'b0;
    logic rst = 1'b0;
    int   vec  = 0;
    int   errs = 0;
    exp_t sb[$];

    divisor_if #(.N(N)) bus ();

    divisor #(.N(N)) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (rst && bus.Done) begin
            if (sb.size() == 0) begin
                vec++;
                errs++;
                $display("FAIL unexpected_done: got Done=1 expected no pending result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quociente", 32'(bus.Quociente), 32'(e.quo));
                check("resto",     32'(bus.Resto),     32'(e.res));
                check("divzero",   32'(bus.DivZero),   32'(e.dz));
            end
        end
    end

    task automatic push(input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
        exp_t e;
        e.quo = q;
        e.res = r;
        e.dz  = dz;
        sb.push_back(e);
    endtask

    // Drives one St request; returns #1 after the accepting edge.
    task automatic start(input logic [N-1:0] a, input logic [N-1:0] b, input bit drop);
        @(posedge Clk);
        #1;
        bus.St        = 1'b1;
        bus.Dividendo = a;
        bus.Divisor   = b;
        @(posedge Clk);
        #1;
        if (drop) bus.St = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
        int  cyc  = 0;
        int  bcnt = 0;
        bit  seen = 0;
        while (cyc < 64 && !seen) begin
            @(negedge Clk);
            cyc++;
            if (bus.Done) seen = 1;
            else if (bus.Busy) bcnt++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"},   32'(cyc),  32'(exp_lat));
        check({name, "_busy"},      32'(bcnt), 32'(exp_busy));
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_quo"},  32'(bus.Quociente), 32'd0);
        check({name, "_res"},  32'(bus.Resto),     32'd0);
        check({name, "_done"}, 32'(bus.Done),      32'd0);
        check({name, "_busy"}, 32'(bus.Busy),      32'd0);
        check({name, "_dz"},   32'(bus.DivZero),   32'd0);
    endtask

    initial begin
        bus.St        = 1'b0;
        bus.Dividendo = '0;
        bus.Divisor   = '0;
        #12;
        check_idle_zero("reset");
        @(negedge Clk);
        rst = 1'b1;

        push(16'd14, 16'd2, 1'b0);
        start(16'd100, 16'd7, 1'b1);
        wait_done("div_100_7", 16, 15);

        push(16'hFFFF, 16'h0000, 1'b0);
        start(16'hFFFF, 16'h0001, 1'b1);
        wait_done("div_ffff_1", 16, 15);

        push(16'h0001, 16'h7FFF, 1'b0);
        start(16'hFFFF, 16'h8000, 1'b1);
        wait_done("div_ffff_8000", 16, 15);

        push(16'hFFFF, 16'd5, 1'b1);
        start(16'd5, 16'd0, 1'b1);
        wait_done("div_5_0", 1, 0);

        push(16'd0, 16'd3, 1'b0);
        start(16'd3, 16'd10, 1'b1);
        wait_done("div_3_10", 16, 15);

        repeat (4) @(negedge Clk);
        check("hold_quo", 32'(bus.Quociente), 32'd0);
        check("hold_res", 32'(bus.Resto),     32'd3);

        // St held high: operand change mid-run is ignored, then picked up from FIM.
        push(16'd8, 16'd2, 1'b0);
        push(16'd4, 16'd1, 1'b0);
        start(16'd50, 16'd6, 1'b0);
        bus.Dividendo = 16'd9;
        bus.Divisor   = 16'd2;
        wait_done("div_50_6", 16, 15);
        @(posedge Clk);
        #1;
        bus.St = 1'b0;
        wait_done("div_9_2", 16, 15);

        start(16'd1000, 16'd3, 1'b1);
        repeat (5) @(negedge Clk);
        #2;
        rst = 1'b0;
        #1;
        check_idle_zero("async_reset");
        repeat (3) @(posedge Clk);
        #1;
        check_idle_zero("held_reset");
        @(negedge Clk);
        rst = 1'b1;
        repeat (20) @(negedge Clk);

        push(16'd5, 16'd0, 1'b0);
        start(16'd20, 16'd4, 1'b1);
        wait_done("div_20_4", 16, 15);

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
